// File: rtl/mmac_term_pe.sv
// Term-serial multiply-accumulate PE: applies up to MAX_BUDGET power-of-two terms per pass.
// Build option: define MMAC_SAT_EN for saturating accumulators (default wraps).
module mmac_term_pe #(
    parameter int GROUP_SIZE = 8,
    parameter int DATA_WIDTH = 3,
    parameter int WGT_WIDTH  = 3,
    parameter int MAX_BUDGET = 4,
    parameter int ACC_WIDTH  = 16,
    localparam int IDX_WIDTH = $clog2(GROUP_SIZE),
    localparam int BW        = $clog2(MAX_BUDGET + 1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             update_w_i,
    input  logic                             update_idx_i,
    input  logic                             start_i,
    input  logic [BW-1:0]                    budget_i,
    input  logic [DATA_WIDTH*GROUP_SIZE-1:0] data_in,
    input  logic [GROUP_SIZE-1:0]            data_sign_in,
    input  logic [ACC_WIDTH-1:0]             pos_acc,
    input  logic [ACC_WIDTH-1:0]             neg_acc,
    input  logic                             out_ready_i,
    output logic                             update_w_o,
    output logic                             update_idx_o,
    output logic                             start_o,
    output logic [DATA_WIDTH*GROUP_SIZE-1:0] data_out,
    output logic [GROUP_SIZE-1:0]            data_sign_out,
    output logic [ACC_WIDTH-1:0]             out_pos,
    output logic [ACC_WIDTH-1:0]             out_neg,
    output logic                             out_valid_o,
    output logic                             busy_o
);

    localparam int SHW      = WGT_WIDTH + 1;
    localparam int KW       = (MAX_BUDGET > 1) ? $clog2(MAX_BUDGET) : 1;
    localparam int IBUS_W   = DATA_WIDTH * GROUP_SIZE + GROUP_SIZE;
    localparam int IDX_BITS = IDX_WIDTH * MAX_BUDGET;

    generate
        if (IBUS_W < IDX_BITS) begin : g_idx_bus_too_narrow
            $error("mmac_term_pe: {data_in, data_sign_in} narrower than IDX_WIDTH*MAX_BUDGET");
        end
        if (WGT_WIDTH * MAX_BUDGET > DATA_WIDTH * GROUP_SIZE) begin : g_wgt_bus_too_narrow
            $error("mmac_term_pe: data_in narrower than WGT_WIDTH*MAX_BUDGET");
        end
        if (MAX_BUDGET > GROUP_SIZE) begin : g_sign_bus_too_narrow
            $error("mmac_term_pe: data_sign_in narrower than MAX_BUDGET");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Weight/index stores, reloaded only on explicit update requests
    logic [WGT_WIDTH-1:0]  r_wexp [MAX_BUDGET];
    logic [MAX_BUDGET-1:0] r_wsign;
    logic [IDX_WIDTH-1:0]  r_idx  [MAX_BUDGET];

    // Per-pass snapshot of activations and seeds
    logic [DATA_WIDTH-1:0] r_dexp [GROUP_SIZE];
    logic [GROUP_SIZE-1:0] r_dsign;
    logic [ACC_WIDTH-1:0]  r_acc_pos;
    logic [ACC_WIDTH-1:0]  r_acc_neg;
    logic [BW-1:0]         r_budget;
    logic [KW-1:0]         r_k;

    logic [ACC_WIDTH-1:0]  r_out_pos;
    logic [ACC_WIDTH-1:0]  r_out_neg;
    logic                  r_out_valid;

    logic                             r_update_w_fwd;
    logic                             r_update_idx_fwd;
    logic                             r_start_fwd;
    logic [DATA_WIDTH*GROUP_SIZE-1:0] r_data_fwd;
    logic [GROUP_SIZE-1:0]            r_sign_fwd;

    logic [DATA_WIDTH-1:0] w_din_exp [GROUP_SIZE];
    logic [WGT_WIDTH-1:0]  w_ld_wexp [MAX_BUDGET];
    logic [IDX_WIDTH-1:0]  w_ld_idx  [MAX_BUDGET];
    logic [IDX_BITS-1:0]   w_idx_bus;

    logic                  w_load_w;
    logic                  w_load_idx;
    logic                  w_start;
    logic                  w_last_term;
    logic [BW-1:0]         w_budget_clip;

    logic [IDX_WIDTH-1:0]  w_lane;
    logic [SHW-1:0]        w_shift;
    logic                  w_shift_oor;
    logic                  w_term_sign;
    logic [ACC_WIDTH-1:0]  w_term;

    // Index slots are packed LSB-first across the combined sign/data bus
    assign w_idx_bus = IDX_BITS'({data_in, data_sign_in});

    genvar gi;
    generate
        for (gi = 0; gi < GROUP_SIZE; gi++) begin : g_lane
            assign w_din_exp[gi] = data_in[gi*DATA_WIDTH +: DATA_WIDTH];
        end
        for (gi = 0; gi < MAX_BUDGET; gi++) begin : g_slot
            assign w_ld_wexp[gi] = data_in[gi*WGT_WIDTH +: WGT_WIDTH];
            assign w_ld_idx[gi]  = w_idx_bus[gi*IDX_WIDTH +: IDX_WIDTH];
        end
    endgenerate

    assign w_budget_clip = (budget_i > BW'(MAX_BUDGET)) ? BW'(MAX_BUDGET) : budget_i;
    assign w_last_term   = ((BW'(r_k) + BW'(1)) == r_budget);

    assign w_lane      = r_idx[r_k];
    assign w_shift     = SHW'(r_wexp[r_k]) + SHW'(r_dexp[w_lane]);
    assign w_shift_oor = (32'(w_shift) >= ACC_WIDTH);
    assign w_term_sign = r_wsign[r_k] ^ r_dsign[w_lane];

`ifdef MMAC_SAT_EN
    // An all-ones term always saturates the accumulator it is added to
    assign w_term = w_shift_oor ? '1 : (ACC_WIDTH'(1) << w_shift);

    function automatic logic [ACC_WIDTH-1:0] acc_add(input logic [ACC_WIDTH-1:0] a,
                                                     input logic [ACC_WIDTH-1:0] t);
        logic [ACC_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, t};
        return s[ACC_WIDTH] ? '1 : s[ACC_WIDTH-1:0];
    endfunction
`else
    assign w_term = w_shift_oor ? '0 : (ACC_WIDTH'(1) << w_shift);

    function automatic logic [ACC_WIDTH-1:0] acc_add(input logic [ACC_WIDTH-1:0] a,
                                                     input logic [ACC_WIDTH-1:0] t);
        return a + t;
    endfunction
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load_w     = 1'b0;
        w_load_idx   = 1'b0;
        w_start      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (update_w_i) begin
                    w_load_w = 1'b1;
                end else if (update_idx_i) begin
                    w_load_idx = 1'b1;
                end else if (start_i) begin
                    w_start      = 1'b1;
                    w_state_next = (w_budget_clip == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last_term) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // Result is only consumed once it is actually presented
                if (r_out_valid && out_ready_i) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < MAX_BUDGET; k++) begin
                r_wexp[k] <= '0;
                r_idx[k]  <= '0;
            end
            r_wsign <= '0;
        end else begin
            if (w_load_w) begin
                for (int k = 0; k < MAX_BUDGET; k++) begin
                    r_wexp[k] <= w_ld_wexp[k];
                end
                r_wsign <= data_sign_in[MAX_BUDGET-1:0];
            end
            if (w_load_idx) begin
                for (int k = 0; k < MAX_BUDGET; k++) begin
                    r_idx[k] <= w_ld_idx[k];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < GROUP_SIZE; j++) begin
                r_dexp[j] <= '0;
            end
            r_dsign   <= '0;
            r_acc_pos <= '0;
            r_acc_neg <= '0;
            r_budget  <= '0;
            r_k       <= '0;
        end else if (w_start) begin
            for (int j = 0; j < GROUP_SIZE; j++) begin
                r_dexp[j] <= w_din_exp[j];
            end
            r_dsign   <= data_sign_in;
            r_acc_pos <= pos_acc;
            r_acc_neg <= neg_acc;
            r_budget  <= w_budget_clip;
            r_k       <= '0;
        end else if (r_state == ST_RUN) begin
            if (w_term_sign) begin
                r_acc_neg <= acc_add(r_acc_neg, w_term);
            end else begin
                r_acc_pos <= acc_add(r_acc_pos, w_term);
            end
            r_k <= w_last_term ? '0 : r_k + KW'(1);
        end
    end

    // Result registers load on the first DONE cycle, giving B+1 cycles of latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_pos   <= '0;
            r_out_neg   <= '0;
            r_out_valid <= 1'b0;
        end else if (r_state == ST_DONE) begin
            if (!r_out_valid) begin
                r_out_pos   <= r_acc_pos;
                r_out_neg   <= r_acc_neg;
                r_out_valid <= 1'b1;
            end else if (out_ready_i) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_update_w_fwd   <= 1'b0;
            r_update_idx_fwd <= 1'b0;
            r_start_fwd      <= 1'b0;
            r_data_fwd       <= '0;
            r_sign_fwd       <= '0;
        end else begin
            r_update_w_fwd   <= update_w_i;
            r_update_idx_fwd <= update_idx_i;
            r_start_fwd      <= start_i;
            r_data_fwd       <= data_in;
            r_sign_fwd       <= data_sign_in;
        end
    end

    assign update_w_o    = r_update_w_fwd;
    assign update_idx_o  = r_update_idx_fwd;
    assign start_o       = r_start_fwd;
    assign data_out      = r_data_fwd;
    assign data_sign_out = r_sign_fwd;
    assign out_pos       = r_out_pos;
    assign out_neg       = r_out_neg;
    assign out_valid_o   = r_out_valid;
    assign busy_o        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mmac_term_pe.sv
// Directed-vector bench for mmac_term_pe with hand-computed sums and latencies.
module tb_mmac_term_pe;

    logic        clk = 1'b0;
    logic        reset;
    logic        update_w_i;
    logic        update_idx_i;
    logic        start_i;
    logic [2:0]  budget_i;
    logic [23:0] data_in;
    logic [7:0]  data_sign_in;
    logic [15:0] pos_acc;
    logic [15:0] neg_acc;
    logic        out_ready_i;
    logic        update_w_o;
    logic        update_idx_o;
    logic        start_o;
    logic [23:0] data_out;
    logic [7:0]  data_sign_out;
    logic [15:0] out_pos;
    logic [15:0] out_neg;
    logic        out_valid_o;
    logic        busy_o;

    int n_vec = 0;
    int n_err = 0;

    mmac_term_pe dut (
        .clk          (clk),
        .reset        (reset),
        .update_w_i   (update_w_i),
        .update_idx_i (update_idx_i),
        .start_i      (start_i),
        .budget_i     (budget_i),
        .data_in      (data_in),
        .data_sign_in (data_sign_in),
        .pos_acc      (pos_acc),
        .neg_acc      (neg_acc),
        .out_ready_i  (out_ready_i),
        .update_w_o   (update_w_o),
        .update_idx_o (update_idx_o),
        .start_o      (start_o),
        .data_out     (data_out),
        .data_sign_out(data_sign_out),
        .out_pos      (out_pos),
        .out_neg      (out_neg),
        .out_valid_o  (out_valid_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Weight load, optionally with a simultaneous start that must be dropped
    task automatic load_w(input logic [11:0] wexp, input logic [3:0] ws, input logic with_start);
        data_in      = {12'd0, wexp};
        data_sign_in = {4'd0, ws};
        update_w_i   = 1'b1;
        start_i      = with_start;
        budget_i     = 3'd4;
        tick();
        update_w_i = 1'b0;
        start_i    = 1'b0;
        check("load_w_busy", 32'(busy_o), 32'd0);
        check("load_w_fwd_flag", 32'(update_w_o), 32'd1);
        check("load_w_fwd_data", 32'(data_out), {20'd0, wexp});
    endtask

    task automatic load_idx(input logic [11:0] idxp, input logic with_start);
        logic [31:0] bus;
        bus          = {20'd0, idxp};
        data_in      = bus[31:8];
        data_sign_in = bus[7:0];
        update_idx_i = 1'b1;
        start_i      = with_start;
        budget_i     = 3'd4;
        tick();
        update_idx_i = 1'b0;
        start_i      = 1'b0;
        check("load_idx_busy", 32'(busy_o), 32'd0);
        check("load_idx_fwd_flag", 32'(update_idx_o), 32'd1);
    endtask

    // One pass: start, scramble inputs, wait for valid, optional hold, handshake with a dropped start
    task automatic run_pass(input string tag, input logic [23:0] act, input logic [7:0] asign,
                            input logic [2:0] b, input logic [15:0] seed_p, input logic [15:0] seed_n,
                            input logic [15:0] exp_p, input logic [15:0] exp_n, input int exp_lat,
                            input int hold);
        int lat;
        data_in      = act;
        data_sign_in = asign;
        budget_i     = b;
        pos_acc      = seed_p;
        neg_acc      = seed_n;
        start_i      = 1'b1;
        tick();
        start_i      = 1'b0;
        data_in      = 24'($urandom);
        data_sign_in = 8'($urandom);
        pos_acc      = 16'($urandom);
        neg_acc      = 16'($urandom);
        check({tag, "_busy"}, 32'(busy_o), 32'd1);
        lat = 0;
        while (out_valid_o !== 1'b1 && lat < 30) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_pos"}, 32'(out_pos), 32'(exp_p));
        check({tag, "_neg"}, 32'(out_neg), 32'(exp_n));
        for (int i = 0; i < hold; i++) begin
            start_i      = i[0];
            update_w_i   = ~i[0];
            data_in      = 24'($urandom);
            data_sign_in = 8'($urandom);
            tick();
            check({tag, "_hold_valid"}, 32'(out_valid_o), 32'd1);
            check({tag, "_hold_pos"}, 32'(out_pos), 32'(exp_p));
            check({tag, "_hold_neg"}, 32'(out_neg), 32'(exp_n));
        end
        update_w_i  = 1'b0;
        start_i     = 1'b1;
        out_ready_i = 1'b1;
        tick();
        start_i     = 1'b0;
        out_ready_i = 1'b0;
        check({tag, "_ack_valid"}, 32'(out_valid_o), 32'd0);
        check({tag, "_ack_busy"}, 32'(busy_o), 32'd0);
        tick();
        check({tag, "_idle_busy"}, 32'(busy_o), 32'd0);
    endtask

    logic [15:0] exp_wrap;

    initial begin
        reset        = 1'b1;
        update_w_i   = 1'b0;
        update_idx_i = 1'b0;
        start_i      = 1'b0;
        budget_i     = 3'd0;
        data_in      = 24'd0;
        data_sign_in = 8'd0;
        pos_acc      = 16'd0;
        neg_acc      = 16'd0;
        out_ready_i  = 1'b0;
        tick();
        tick();
        check("rst_pos", 32'(out_pos), 32'd0);
        check("rst_neg", 32'(out_neg), 32'd0);
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_fwd", 32'({start_o, update_w_o, update_idx_o, data_sign_out}), 32'd0);
        reset = 1'b0;
        tick();

        // Weights {1,2,0,3}, idx {0,1,2,3}; both loads carry a start that must be dropped
        load_w({3'd3, 3'd0, 3'd2, 3'd1}, 4'b0000, 1'b1);
        load_idx({3'd3, 3'd2, 3'd1, 3'd0}, 1'b1);
        run_pass("base", {8{3'd1}}, 8'h00, 3'd4, 16'd0, 16'd0, 16'd30, 16'd0, 5, 10);
        run_pass("reuse", {8{3'd1}}, 8'h00, 3'd4, 16'd0, 16'd0, 16'd30, 16'd0, 5, 0);

        load_w({3'd3, 3'd0, 3'd2, 3'd1}, 4'b0010, 1'b0);
        run_pass("b2", {8{3'd1}}, 8'h00, 3'd2, 16'd0, 16'd0, 16'd4, 16'd8, 3, 0);
        run_pass("b0", {8{3'd1}}, 8'h00, 3'd0, 16'd7, 16'd5, 16'd7, 16'd5, 1, 0);
        run_pass("b7", {8{3'd1}}, 8'h00, 3'd7, 16'd0, 16'd0, 16'd22, 16'd8, 5, 0);

`ifdef MMAC_SAT_EN
        exp_wrap = 16'hFFFF;
`else
        exp_wrap = 16'h0000;
`endif
        load_w({3'd0, 3'd0, 3'd0, 3'd1}, 4'b0000, 1'b0);
        run_pass("ovf", 24'd3, 8'h00, 3'd1, 16'hFFF0, 16'd0, exp_wrap, 16'd0, 2, 0);

        // Mixed lanes/signs: neg 256+32+32 over seed 1000, pos 16 over seed 100
        load_w({3'd3, 3'd1, 3'd0, 3'd2}, 4'b1010, 1'b0);
        load_idx({3'd0, 3'd5, 3'd5, 3'd7}, 1'b0);
        run_pass("mix", {3'd6, 3'd0, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2}, 8'hA0,
                 3'd4, 16'd100, 16'd1000, 16'd116, 16'd1320, 5, 0);

        // Abort a pass at term 2 with reset
        data_in      = {3'd6, 3'd0, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2};
        data_sign_in = 8'hA0;
        budget_i     = 3'd4;
        pos_acc      = 16'd100;
        neg_acc      = 16'd1000;
        start_i      = 1'b1;
        tick();
        start_i      = 1'b0;
        data_in      = 24'hABCDEF;
        data_sign_in = 8'h5A;
        tick();
        tick();
        check("abort_busy_pre", 32'(busy_o), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_valid", 32'(out_valid_o), 32'd0);
        check("abort_out", 32'({out_pos, out_neg}), 32'd0);
        check("abort_fwd", 32'(data_out), 32'd0);
        check("abort_fwd_sign", 32'(data_sign_out), 32'd0);
        tick();
        check("abort_valid_hold", 32'(out_valid_o), 32'd0);
        reset = 1'b0;
        tick();
        load_w({3'd3, 3'd1, 3'd0, 3'd2}, 4'b1010, 1'b0);
        load_idx({3'd0, 3'd5, 3'd5, 3'd7}, 1'b0);
        run_pass("post", {3'd6, 3'd0, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2}, 8'hA0,
                 3'd4, 16'd100, 16'd1000, 16'd116, 16'd1320, 5, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
